spi_rx_frontend: RTL
====================

# spi_rx_frontend

Serial receive front-end between the off-chip SPI pins (SCK, SS_N, SDI) and the serial-to-parallel shift register. It synchronises the pins into CLK, detects sampling edges on SCK, and drives the shifter's serial input and chip-enable. It counts bits, captures the shifter's parallel output into a holding register once a full word is received, and hands the word downstream with a valid/ready handshake and a sticky overrun flag.

## Interface
- WIDTH, 8: word length in bits; must match the shift register width; ≥2
- SYNC_STAGES, 2: flops per pin synchroniser; ≥2
- CLK  in  1  system clock; all logic on rising edge
- RSTN  in  1  asynchronous, active-low reset
- SCK  in  1  SPI clock pin, asynchronous to CLK
- SS_N  in  1  SPI select pin, active low, asynchronous
- SDI  in  1  SPI data pin, MSB first, asynchronous
- D  out  1  serial bit to shift register
- CE  out  1  one-cycle shift strobe to shift register
- Q_IN  in  WIDTH  parallel output read back from shift register
- DATA  out  WIDTH  captured word
- VALID  out  1  DATA holds an unconsumed word
- READY  in  1  downstream accepts DATA when VALID && READY
- OVERRUN  out  1  sticky: a completed word was dropped
- OVR_CLR  in  1  clears OVERRUN
- BUSY  out  1  SS_N synchronised low (frame active)

## Operation
- Synchronisers on SCK, SS_N, SDI; reset values 0, 1, 0 respectively. Registered sck_prev (reset 0).
- Sampling edge: rising (sck_sync && !sck_prev) while ss_sync low.
- On sampling edge: next cycle CE=1, D=sdi_sync of the edge cycle; otherwise CE=0, D holds.
- Bit counter, log2(WIDTH)+1 bits, reset 0: increments on each issued CE; on CE with count WIDTH-1, wraps to 0 and sets capture_pend.
- capture_pend delays one cycle (shifter updates on CE edge), then capture: Q_IN → DATA.
- Capture when VALID=0, or VALID=1 and READY=1 same cycle: DATA loads, VALID=1, no overrun.
- Capture when VALID=1 and READY=0: word dropped, DATA unchanged, OVERRUN←1.
- VALID && READY with no capture: VALID←0.
- OVR_CLR: OVERRUN←0; if an overrun occurs the same cycle, set wins.
- ss_sync high: bit counter←0, CE suppressed, partial word discarded; pending capture (already complete word) still completes. SS_N deassert coincident with a sampling edge: deassert wins, no CE.
- BUSY = !ss_sync.
- Reset values: D=0, CE=0, DATA=0, VALID=0, OVERRUN=0, BUSY=0, counter=0, capture_pend=0. Reset mid-frame abandons everything immediately.

## Timing
- SCK pin rises before CLK edge e1: CE high after edge e1+SYNC_STAGES, for exactly one cycle.
- Final CE of word at cycle n: shifter updates at edge n+1, DATA/VALID update at edge n+2 (VALID 2 cycles after final CE).
- SDI must be stable ≥SYNC_STAGES+1 CLK periods around the sampling SCK edge; SCK high and low phases each ≥SYNC_STAGES+1 CLK periods. Violations give undefined data, no lock-up.
- VALID drops the cycle after the accepting handshake edge; DATA stable while VALID=1 and READY=0.

## Configuration
- SPI_RX_FALLING_EDGE_EN defined: sampling edge is falling (!sck_sync && sck_prev); sck_prev and SCK sync stages reset to 1.
- Undefined: rising-edge sampling as above. All other behaviour identical.

## Test plan
- WIDTH=8, SS_N low, shift 0xA5 MSB first with 8 SCK pulses, READY=1 -> exactly 8 CE pulses, DATA=0xA5, VALID one cycle, OVERRUN=0.
- Two back-to-back words 0x3C, 0xC3 with READY=0 -> DATA=0x3C stays, OVERRUN=1; OVR_CLR pulse -> OVERRUN=0; READY=1 -> VALID falls.
- SS_N raised after 5 bits, then new frame 0x81 -> no capture from partial frame, DATA=0x81 after 8 bits.
- Single SCK rising edge, SYNC_STAGES=2 -> CE high exactly after 3rd CLK edge following pin change, width 1 cycle.
- Capture coincident with VALID&&READY (word 0x12 pending, new word 0x34) -> DATA=0x34, VALID stays 1, OVERRUN=0.
- RSTN asserted after 4 bits, released, full word 0xFF -> all outputs at reset values during reset, then DATA=0xFF; repeat with SPI_RX_FALLING_EDGE_EN defined.

Source files
------------

// File: rtl/spi_rx_frontend_if.sv
// Signal bundle between the SPI receive front-end, the SPI pins, the external shifter and the downstream consumer.
interface spi_rx_frontend_if #(
  parameter int WIDTH = 8
);
  logic             SCK;
  logic             SS_N;
  logic             SDI;
  logic             D;
  logic             CE;
  logic [WIDTH-1:0] Q_IN;
  logic [WIDTH-1:0] DATA;
  logic             VALID;
  logic             READY;
  logic             OVERRUN;
  logic             OVR_CLR;
  logic             BUSY;

  modport slave (
    input  SCK, SS_N, SDI, Q_IN, READY, OVR_CLR,
    output D, CE, DATA, VALID, OVERRUN, BUSY
  );

  modport master (
    output SCK, SS_N, SDI, Q_IN, READY, OVR_CLR,
    input  D, CE, DATA, VALID, OVERRUN, BUSY
  );
endinterface

// File: rtl/spi_rx_frontend.sv
// SPI receive front-end: pin synchronisers, SCK edge detect, shifter strobe, bit counting and word hand-off.
// Define SPI_RX_FALLING_EDGE_EN to sample on the falling SCK edge instead of the rising edge.
module spi_rx_frontend #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic              CLK,
  input logic              RSTN,
  spi_rx_frontend_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef SPI_RX_FALLING_EDGE_EN
  localparam logic SCK_RST = 1'b1;
`else
  localparam logic SCK_RST = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ce_q, ce_d;
  logic                   d_q, d_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;

  logic sck_sync;
  logic ss_sync;
  logic sdi_sync;
  logic samp_edge;

  assign sck_sync = sck_sync_q[SYNC_STAGES-1];
  assign ss_sync  = ss_sync_q[SYNC_STAGES-1];
  assign sdi_sync = sdi_sync_q[SYNC_STAGES-1];

  // A deasserting select in the same cycle as the edge suppresses the strobe.
`ifdef SPI_RX_FALLING_EDGE_EN
  assign samp_edge = !sck_sync && sck_prev_q && !ss_sync;
`else
  assign samp_edge = sck_sync && !sck_prev_q && !ss_sync;
`endif

  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
    ss_sync_d  = {ss_sync_q[SYNC_STAGES-2:0], bus.SS_N};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], bus.SDI};
    sck_prev_d = sck_sync;
    ce_d       = samp_edge;
    d_d        = samp_edge ? sdi_sync : d_q;
  end

  // A word completed by the last strobe still gets captured even if select rises meanwhile.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = 1'b0;
    if (ce_q) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d  = '0;
        pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (ss_sync) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (bus.OVR_CLR) begin
      ovr_d = 1'b0;
    end
    if (pend_q) begin
      if (!valid_q || bus.READY) begin
        data_d  = bus.Q_IN;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sck_sync_q <= {SYNC_STAGES{SCK_RST}};
      ss_sync_q  <= {SYNC_STAGES{1'b1}};
      sdi_sync_q <= '0;
      sck_prev_q <= SCK_RST;
      ce_q       <= 1'b0;
      d_q        <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ss_sync_q  <= ss_sync_d;
      sdi_sync_q <= sdi_sync_d;
      sck_prev_q <= sck_prev_d;
      ce_q       <= ce_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.D       = d_q;
  assign bus.CE      = ce_q;
  assign bus.DATA    = data_q;
  assign bus.VALID   = valid_q;
  assign bus.OVERRUN = ovr_q;
  assign bus.BUSY    = !ss_sync;

endmodule
